// File: rtl/proc_loader_pkg.sv
// Shared definitions for the boot loader: FSM states and stream field sizes.
package proc_loader_pkg;

    typedef enum logic [2:0] {
        S_ADDR  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_e;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/proc_loader_wordasm.sv
// Little-endian 4-byte assembler; word_valid pulses with the 4th accepted byte,
// and word presents the completed value in that same cycle.
module proc_loader_wordasm
    import proc_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    logic [1:0]  cnt_r;
    logic [23:0] acc_r;

    // Byte counter and shift register; earlier bytes drift toward the low end.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= 2'd0;
            acc_r <= 24'd0;
        end else if (clr) begin
            cnt_r <= 2'd0;
            acc_r <= 24'd0;
        end else if (en) begin
            cnt_r <= cnt_r + 2'd1;
            acc_r <= {byte_in, acc_r[23:8]};
        end
    end

    // Completed word and its strobe.
    always_comb begin
        word       = {byte_in, acc_r};
        word_valid = en && !clr && (cnt_r == LAST_BYTE);
    end

endmodule

// File: rtl/proc_loader.sv
// Boot loader: parses a base/count/data byte stream, writes each word to processor
// memory, and keeps the processor in reset until the load has completed.
module proc_loader
    import proc_loader_pkg::*;
#(
    parameter int MAX_WORDS = 4096,
    parameter int RST_HOLD  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [7:0]  in_data,
    input  logic        restart,
    output logic        ext_dmemreq_val,
    output logic        ext_dmemreq_type,
    output logic [31:0] ext_dmemreq_addr,
    output logic [31:0] ext_dmemreq_wdata,
    output logic        proc_rst,
    output logic        done,
    output logic        error,
    output logic [31:0] words_written
);

    state_e      state_r, state_next;
    logic [31:0] base_r, count_r, words_written_r, hold_cnt_r;
    logic [31:0] asm_word;
    logic        asm_valid, fire_s, restart_ok_s;
    logic        req_val_r, req_type_r, proc_rst_r, done_r, error_r;
    logic [31:0] req_addr_r, req_wdata_r;

    proc_loader_wordasm u_wordasm (
        .clk        (clk),
        .rst        (rst),
        .clr        (restart_ok_s),
        .en         (fire_s),
        .byte_in    (in_data),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    // Stream handshake decode; ready only in the three assembling states.
    always_comb begin
        in_rdy = 1'b0;
        case (state_r)
            S_ADDR, S_COUNT, S_DATA: in_rdy = rst;
            default:                 in_rdy = 1'b0;
        endcase
        fire_s       = in_val && in_rdy;
        restart_ok_s = restart && ((state_r == S_DONE) || (state_r == S_ERROR));
    end

    // Next-state logic.
    always_comb begin
        state_next = state_r;
        case (state_r)
            S_ADDR: begin
                if (asm_valid) begin
                    state_next = (asm_word[1:0] != 2'b00) ? S_ERROR : S_COUNT;
                end else begin
                    state_next = S_ADDR;
                end
            end
            S_COUNT: begin
                if (!asm_valid) begin
                    state_next = S_COUNT;
                end else if (asm_word == 32'd0) begin
                    state_next = S_HOLD;
                end else if (asm_word > 32'(MAX_WORDS)) begin
                    state_next = S_ERROR;
                end else begin
                    state_next = S_DATA;
                end
            end
            S_DATA:  state_next = asm_valid ? S_WRITE : S_DATA;
            S_WRITE: state_next = ((words_written_r + 32'd1) == count_r) ? S_HOLD : S_DATA;
            S_HOLD:  state_next = (hold_cnt_r == 32'(RST_HOLD - 1)) ? S_DONE : S_HOLD;
            S_DONE, S_ERROR: begin
                if (restart_ok_s) begin
                    state_next = S_ADDR;
                end else begin
                    state_next = state_r;
                end
            end
            default: state_next = S_ADDR;
        endcase
    end

    // State, header fields and counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r         <= S_ADDR;
            base_r          <= 32'd0;
            count_r         <= 32'd0;
            words_written_r <= 32'd0;
            hold_cnt_r      <= 32'd0;
        end else begin
            state_r <= state_next;
            if ((state_r == S_ADDR) && asm_valid) begin
                base_r <= asm_word;
            end
            if ((state_r == S_COUNT) && asm_valid) begin
                count_r <= asm_word;
            end
            if (restart_ok_s) begin
                words_written_r <= 32'd0;
            end else if (state_r == S_WRITE) begin
                words_written_r <= words_written_r + 32'd1;
            end
            hold_cnt_r <= (state_r == S_HOLD) ? hold_cnt_r + 32'd1 : 32'd0;
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_val_r   <= 1'b0;
            req_type_r  <= 1'b0;
            req_addr_r  <= 32'd0;
            req_wdata_r <= 32'd0;
            proc_rst_r  <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            req_val_r   <= (state_next == S_WRITE);
            req_type_r  <= (state_next == S_WRITE);
            req_addr_r  <= (state_next == S_WRITE) ? base_r + {words_written_r[29:0], 2'b00} : 32'd0;
            req_wdata_r <= (state_next == S_WRITE) ? asm_word : 32'd0;
            proc_rst_r  <= (state_next != S_DONE);
            done_r      <= (state_next == S_DONE);
            error_r     <= (state_next == S_ERROR);
        end
    end

    assign ext_dmemreq_val   = req_val_r;
    assign ext_dmemreq_type  = req_type_r;
    assign ext_dmemreq_addr  = req_addr_r;
    assign ext_dmemreq_wdata = req_wdata_r;
    assign proc_rst          = proc_rst_r;
    assign done              = done_r;
    assign error             = error_r;
    assign words_written     = words_written_r;

endmodule

// File: tb/tb_proc_loader.sv
// Scoreboard bench for proc_loader: expected writes are queued by the stimulus,
// a negedge monitor pops and compares each memory write request.
module tb_proc_loader;

    logic        clk = 1'b0;
    logic        rst, in_val, in_rdy, restart;
    logic [7:0]  in_data;
    logic        ext_dmemreq_val, ext_dmemreq_type;
    logic [31:0] ext_dmemreq_addr, ext_dmemreq_wdata;
    logic        proc_rst, done, error;
    logic [31:0] words_written;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic [31:0] wl[0:7];

    proc_loader #(.MAX_WORDS(4096), .RST_HOLD(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_val            (in_val),
        .in_rdy            (in_rdy),
        .in_data           (in_data),
        .restart           (restart),
        .ext_dmemreq_val   (ext_dmemreq_val),
        .ext_dmemreq_type  (ext_dmemreq_type),
        .ext_dmemreq_addr  (ext_dmemreq_addr),
        .ext_dmemreq_wdata (ext_dmemreq_wdata),
        .proc_rst          (proc_rst),
        .done              (done),
        .error             (error),
        .words_written     (words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write request must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && ext_dmemreq_val === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write",
                         ext_dmemreq_addr, ext_dmemreq_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_type", 32'(ext_dmemreq_type), 32'd1);
                chk("wr_addr", ext_dmemreq_addr, mon_e[63:32]);
                chk("wr_data", ext_dmemreq_wdata, mon_e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 1)) begin
                @(negedge clk);
                in_val = 1'b0;
            end
        end
        @(negedge clk);
        in_val  = 1'b1;
        in_data = b;
        while (!in_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("in_rdy_timeout", 32'(in_rdy), 32'd1);
        end
        @(posedge clk);
        #1;
        in_val = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], gaps);
        end
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (done !== 1'b1 && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done", 32'(done), 32'd1);
    endtask

    task automatic run_load(input logic [31:0] base, input int n, input bit gaps, input bit mid_restart);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({base + 32'(4 * i), wl[i]});
        end
        send_word(base, gaps);
        if (mid_restart) begin
            pulse_restart();
        end
        send_word(32'(n), gaps);
        for (int i = 0; i < n; i++) begin
            send_word(wl[i], gaps);
        end
        wait_done(40);
        chk("words_written", words_written, 32'(n));
        chk("proc_rst_released", 32'(proc_rst), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; in_val = 1'b0; in_data = 8'h00; restart = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_val", 32'(ext_dmemreq_val), 32'd0);
        chk("rst_type", 32'(ext_dmemreq_type), 32'd0);
        chk("rst_addr", ext_dmemreq_addr, 32'd0);
        chk("rst_wdata", ext_dmemreq_wdata, 32'd0);
        chk("rst_proc_rst", 32'(proc_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words", words_written, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("addr_in_rdy", 32'(in_rdy), 32'd1);

        // Two-word load with exact release timing.
        exp_q.push_back({32'h0000_0200, 32'h0000_0013});
        exp_q.push_back({32'h0000_0204, 32'hDEAD_BEEF});
        send_word(32'h0000_0200, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("hold_proc_rst", 32'(proc_rst), 32'd1);
        chk("hold_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("release_proc_rst", 32'(proc_rst), 32'd0);
        chk("release_done", 32'(done), 32'd1);
        chk("t1_words", words_written, 32'd2);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // Zero-word load.
        pulse_restart();
        chk("restart_done_clr", 32'(done), 32'd0);
        chk("restart_proc_rst", 32'(proc_rst), 32'd1);
        chk("restart_words_clr", words_written, 32'd0);
        run_load(32'h0000_0100, 0, 1'b0, 1'b0);

        // Misaligned base address.
        pulse_restart();
        send_word(32'h0000_0202, 1'b0);
        chk("misalign_error", 32'(error), 32'd1);
        chk("misalign_proc_rst", 32'(proc_rst), 32'd1);
        chk("misalign_in_rdy", 32'(in_rdy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("misalign_error_held", 32'(error), 32'd1);

        // Oversized count, then recovery with a single word.
        pulse_restart();
        chk("restart_err_clr", 32'(error), 32'd0);
        send_word(32'h0000_0400, 1'b0);
        send_word(32'd4097, 1'b0);
        chk("oversize_error", 32'(error), 32'd1);
        chk("oversize_in_rdy", 32'(in_rdy), 32'd0);
        pulse_restart();
        wl[0] = 32'hCAFE_F00D;
        run_load(32'h0000_0300, 1, 1'b0, 1'b0);
        chk("recover_error", 32'(error), 32'd0);

        // Three words, gap-free then with random in_val gaps.
        wl[0] = 32'h0102_0304; wl[1] = 32'hA5A5_5A5A; wl[2] = 32'hFFFF_0000;
        pulse_restart();
        run_load(32'h0000_1000, 3, 1'b0, 1'b0);
        pulse_restart();
        run_load(32'h0000_1000, 3, 1'b1, 1'b0);

        // Address wrap-around.
        wl[0] = 32'h1111_1111; wl[1] = 32'h2222_2222;
        pulse_restart();
        run_load(32'hFFFF_FFFC, 2, 1'b0, 1'b0);

        // Reset in the middle of the first data word.
        pulse_restart();
        send_word(32'h0000_0500, 1'b0);
        send_word(32'd2, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h66, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_in_rdy", 32'(in_rdy), 32'd0);
        chk("midrst_val", 32'(ext_dmemreq_val), 32'd0);
        chk("midrst_proc_rst", 32'(proc_rst), 32'd1);
        chk("midrst_words", words_written, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wl[0] = 32'h1234_5678; wl[1] = 32'h9ABC_DEF0;
        run_load(32'h0000_0500, 2, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/proc_loader.md
Name: proc_loader

Overview:
- Upstream boot loader for the TinyRV1 processor top.
- Consumes a byte stream (host/UART side) carrying a load header and program words, and writes each word into processor memory through the external data-memory request port.
- Holds the processor in reset for the whole load and releases it once the last word is written.
- While the processor runs, the external port is idle, so the processor's internal data requests never compete with the loader.

Parameters:
- MAX_WORDS, 4096, largest word count accepted in one load; a larger count is an error.
- RST_HOLD, 2, cycles proc_rst stays high after the final write before release (must be ≥1).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset (0 = reset)
- in_val  input  1  byte-stream valid
- in_rdy  output  1  byte-stream ready; a byte transfers when in_val && in_rdy
- in_data  input  8  stream byte
- restart  input  1  single-cycle pulse; starts a new load from DONE or ERROR
- ext_dmemreq_val  output  1  memory write request valid (one-cycle pulse per word)
- ext_dmemreq_type  output  1  always 1 (write) when valid, 0 otherwise
- ext_dmemreq_addr  output  32  byte address of the word being written
- ext_dmemreq_wdata  output  32  word being written
- proc_rst  output  1  active-high reset to the processor
- done  output  1  load complete, processor released
- error  output  1  load aborted
- words_written  output  32  count of words committed in the current load

Behaviour:
- Reset (rst=0 at posedge):
  - state=ADDR; byte counter=0; addr, count and words_written cleared.
  - Outputs: in_rdy=0 during the reset cycle; ext_dmemreq_val=0; type=0; addr=0; wdata=0; proc_rst=1; done=0; error=0.
  - Reset mid-load aborts the load; words already written stay in memory.
- Stream format, all fields little-endian: 4-byte base address, 4-byte word count N, then N×4 data bytes.
- States: ADDR, COUNT, DATA, WRITE, HOLD, DONE, ERROR.
- ADDR:
  - in_rdy=1; shift bytes into the base register (byte k goes to bits 8k+7:8k).
  - On the 4th byte, if base[1:0]≠0, go to ERROR; otherwise go to COUNT.
- COUNT:
  - in_rdy=1; assemble N the same way.
  - On the 4th byte: N=0 → HOLD; N>MAX_WORDS → ERROR; otherwise → DATA.
- DATA:
  - in_rdy=1; assemble one word.
  - On the 4th byte, latch the word into the wdata register and go to WRITE.
- WRITE:
  - Exactly one cycle; in_rdy=0.
  - Outputs: ext_dmemreq_val=1, type=1, addr=base+4·words_written, wdata=latched word.
  - Next edge: words_written++. If words_written (after increment) == N → HOLD, else → DATA.
  - Address arithmetic is mod 2^32; wrap-around is allowed and not flagged.
- Latency: one transferred byte per cycle at best. Each word therefore costs 5 cycles (4 bytes + 1 WRITE).
- HOLD:
  - in_rdy=0; proc_rst=1.
  - Counts RST_HOLD cycles, then → DONE.
- DONE:
  - proc_rst=0, done=1, in_rdy=0.
  - Stays here until restart.
- ERROR:
  - error=1, proc_rst=1, in_rdy=0; no memory requests.
  - Stays here until restart.
- restart:
  - Honoured only in DONE or ERROR; ignored in every other state.
  - Next state ADDR: clears words_written, done and error; sets proc_rst=1.
- in_val=0 stalls the assembly with no timeout; partial byte state is kept.
- All outputs are registered except in_rdy, which decodes state combinationally.

Decomposition:
- Shared package proc_loader_pkg: state enum, HDR_BYTES=4, WORD_BYTES=4.
- One sub-module, proc_loader_wordasm: 4-byte little-endian assembler with a 2-bit byte counter, clear/enable inputs and a word_valid pulse on the 4th byte. It is reused for the address, count and data fields.

Test Plan:
- Stream addr 0x00000200, N=2, words 0x00000013, 0xDEADBEEF → two WRITE pulses at addr 0x200/0x204 with that data; words_written=2; proc_rst falls RST_HOLD+1 cycles after the second WRITE; done=1.
- N=0 at addr 0x100 → no ext_dmemreq_val ever; HOLD then DONE; done=1.
- addr 0x00000202 → ERROR after the 4th header byte; error=1; proc_rst stays 1; in_rdy=0; no writes.
- N=MAX_WORDS+1 → ERROR. Then restart pulse plus a valid 1-word stream → a write occurs, done=1, error=0.
- Random in_val gaps (50% duty) on a 3-word load → identical writes and order to the gap-free case.
- rst=0 asserted during DATA of word 1 → next cycle all outputs at reset values, state ADDR. A fresh full stream then loads correctly; restart pulsed outside DONE/ERROR has no effect.
